// File: rtl/vga_chk_pkg.sv
// Shared timing defaults, FSM encoding, counter helpers and CRC constants for the VGA timing checker.
package vga_chk_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // All raster counters share one width and saturate at all-ones (2047).
  localparam int CNT_W = 11;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_timing_checker_crc16_6b.sv
// Combinational CRC-16-CCITT update for one 6-bit pixel symbol, MSB (sym[5]) first.
module crc16_6b
  import vga_chk_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [5:0]  sym,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      if (c[15] ^ sym[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/vga_timing_checker.sv
// Monitors hsync/vsync timing of a VGA stream, locks onto the raster and counts good frames.
// Define VGA_CHK_CRC_EN to add a per-frame CRC-16 of the visible pixels.
module vga_timing_checker
  import vga_chk_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             rrggbb,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   clear,
  output logic                   locked,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [15:0]            frame_crc,
  output logic                   crc_valid,
  output logic                   err_hperiod,
  output logic                   err_hwidth,
  output logic                   err_vlines,
  output logic                   err_vwidth
);

  localparam logic [CNT_W:0]   H_TOT_W  = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [CNT_W:0]   V_TOT_W  = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);

  logic hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, clr_s1_q, clr_s1_d;
  logic hs_dly_q, hs_dly_d, vs_at_h_q, vs_at_h_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, hw_cnt_q, hw_cnt_d, v_cnt_q, v_cnt_d, vw_cnt_q, vw_cnt_d;
  state_t state_q, state_d;
  logic locked_q, locked_d, fc_inc;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  logic e_hper_q, e_hper_d, e_hwid_q, e_hwid_d, e_vlin_q, e_vlin_d, e_vwid_q, e_vwid_d;
  logic h_edge, h_fall, v_edge, v_end, checking, any_err;
  logic hper_bad, hwid_bad, vlin_bad, vwid_bad;

  always_comb begin
    // Syncs are normalised so that 1 always means "pulse active".
    hs_s1_d   = hsync ^ SYNC_ACTIVE_LOW;
    vs_s1_d   = vsync ^ SYNC_ACTIVE_LOW;
    clr_s1_d  = clear;
    hs_dly_d  = hs_s1_q;

    h_edge    = hs_s1_q & ~hs_dly_q;
    h_fall    = ~hs_s1_q & hs_dly_q;
    v_edge    = h_edge & vs_s1_q & ~vs_at_h_q;
    v_end     = h_edge & ~vs_s1_q & vs_at_h_q;
    vs_at_h_d = h_edge ? vs_s1_q : vs_at_h_q;

    h_cnt_d  = h_edge ? '0 : sat_inc(h_cnt_q);
    hw_cnt_d = h_edge ? CNT_W'(1) : (hs_s1_q ? sat_inc(hw_cnt_q) : hw_cnt_q);
    v_cnt_d  = v_edge ? '0 : (h_edge ? sat_inc(v_cnt_q) : v_cnt_q);
    vw_cnt_d = v_edge ? CNT_W'(1) : ((h_edge & vs_s1_q) ? sat_inc(vw_cnt_q) : vw_cnt_q);

    // Without a reference edge the measured intervals are meaningless.
    checking = (state_q != SEARCH);
    hper_bad = checking & h_edge & (({1'b0, h_cnt_q} + 1'b1) != H_TOT_W);
    hwid_bad = checking & h_fall & (hw_cnt_q != H_SYNC_C);
    vlin_bad = checking & v_edge & (({1'b0, v_cnt_q} + 1'b1) != V_TOT_W);
    vwid_bad = checking & v_end & (vw_cnt_q != V_SYNC_C);
    any_err  = hper_bad | hwid_bad | vlin_bad | vwid_bad;

    state_d = state_q;
    fc_inc  = 1'b0;
    case (state_q)
      SEARCH: if (v_edge) state_d = TRACK;
      TRACK: begin
        if (any_err) state_d = SEARCH;
        else if (v_edge) begin
          state_d = LOCKED;
          fc_inc  = 1'b1;
        end
      end
      LOCKED: begin
        if (any_err) state_d = SEARCH;
        else if (v_edge) fc_inc = 1'b1;
      end
      default: state_d = SEARCH;
    endcase
    locked_d = (state_d == LOCKED);

    // A clear landing with a new error keeps that error; it also wins over a count.
    fc_d     = clr_s1_q ? '0 : fc_q + {{(FRAME_CNT_W-1){1'b0}}, fc_inc};
    e_hper_d = (e_hper_q & ~clr_s1_q) | hper_bad;
    e_hwid_d = (e_hwid_q & ~clr_s1_q) | hwid_bad;
    e_vlin_d = (e_vlin_q & ~clr_s1_q) | vlin_bad;
    e_vwid_d = (e_vwid_q & ~clr_s1_q) | vwid_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
      clr_s1_q  <= 1'b0;
      hs_dly_q  <= 1'b0;
      vs_at_h_q <= 1'b0;
      h_cnt_q   <= '0;
      hw_cnt_q  <= '0;
      v_cnt_q   <= '0;
      vw_cnt_q  <= '0;
      state_q   <= SEARCH;
      locked_q  <= 1'b0;
      fc_q      <= '0;
      e_hper_q  <= 1'b0;
      e_hwid_q  <= 1'b0;
      e_vlin_q  <= 1'b0;
      e_vwid_q  <= 1'b0;
    end else begin
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      clr_s1_q  <= clr_s1_d;
      hs_dly_q  <= hs_dly_d;
      vs_at_h_q <= vs_at_h_d;
      h_cnt_q   <= h_cnt_d;
      hw_cnt_q  <= hw_cnt_d;
      v_cnt_q   <= v_cnt_d;
      vw_cnt_q  <= vw_cnt_d;
      state_q   <= state_d;
      locked_q  <= locked_d;
      fc_q      <= fc_d;
      e_hper_q  <= e_hper_d;
      e_hwid_q  <= e_hwid_d;
      e_vlin_q  <= e_vlin_d;
      e_vwid_q  <= e_vwid_d;
    end
  end

  assign locked      = locked_q;
  assign frame_count = fc_q;
  assign err_hperiod = e_hper_q;
  assign err_hwidth  = e_hwid_q;
  assign err_vlines  = e_vlin_q;
  assign err_vwidth  = e_vwid_q;

`ifdef VGA_CHK_CRC_EN
  localparam logic [CNT_W-1:0] H_VIS_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_VIS_HI = CNT_W'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_VIS_HI = CNT_W'(V_SYNC + V_BACK + V_VISIBLE);

  logic [5:0]  pix_s1_q, pix_s1_d;
  logic [15:0] crc_q, crc_d, crc_nxt, frame_crc_q, frame_crc_d;
  logic        crc_valid_q, crc_valid_d, visible, publish;

  crc16_6b u_crc (.crc_in(crc_q), .sym(pix_s1_q), .crc_out(crc_nxt));

  always_comb begin
    pix_s1_d = rrggbb;
    // The _d counters give the raster position of the pixel currently in S1.
    visible  = (h_cnt_d >= H_VIS_LO) && (h_cnt_d < H_VIS_HI) &&
               (v_cnt_d >= V_VIS_LO) && (v_cnt_d < V_VIS_HI);
    publish     = v_edge & checking & ~any_err;
    crc_d       = v_edge ? CRC_INIT : (visible ? crc_nxt : crc_q);
    frame_crc_d = publish ? crc_q : frame_crc_q;
    crc_valid_d = publish;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s1_q    <= '0;
      crc_q       <= CRC_INIT;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      pix_s1_q    <= pix_s1_d;
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  logic unused_pix;
  assign unused_pix = ^rrggbb;
  assign frame_crc  = '0;
  assign crc_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_checker.sv
// Table-driven bench for vga_timing_checker on a shrunken raster (16 clocks x 11 lines per frame).
module tb_vga_timing_checker;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n, hsync, vsync, clear;
  logic [5:0] rrggbb;
  logic locked, crc_valid, err_hperiod, err_hwidth, err_vlines, err_vwidth;
  logic [3:0] frame_count;
  logic [15:0] frame_crc;

  vga_timing_checker #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1), .FRAME_CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rrggbb(rrggbb), .hsync(hsync), .vsync(vsync), .clear(clear),
    .locked(locked), .frame_count(frame_count), .frame_crc(frame_crc), .crc_valid(crc_valid),
    .err_hperiod(err_hperiod), .err_hwidth(err_hwidth), .err_vlines(err_vlines), .err_vwidth(err_vwidth)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, pulses = 0, lock_rise = -1, lock_fall = -1, hper_rise = -1;
  int fstart = 0, bad_cyc = 0;
  logic lk_p = 1'b0, hp_p = 1'b0;
  logic [15:0] last_crc = '0;
  logic [15:0] crc_m [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (locked && !lk_p) lock_rise = cyc;
    if (!locked && lk_p) lock_fall = cyc;
    if (err_hperiod && !hp_p) hper_rise = cyc;
    if (crc_valid) begin
      pulses++;
      last_crc = frame_crc;
    end
    lk_p = locked;
    hp_p = err_hperiod;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic vis(input int p, input int l);
    return (p >= HS + HB) && (p < HS + HB + HV) && (l >= VS + VB) && (l < VS + VB + VV);
  endfunction

  function automatic logic [5:0] pix(input int pat, input int p, input int l);
    logic [5:0] bars [8];
    bars = '{6'h00, 6'h03, 6'h0C, 6'h0F, 6'h30, 6'h33, 6'h3C, 6'h3F};
    if (!vis(p, l)) return 6'h2A;
    case (pat)
      0:       return 6'h3F;
      1:       return 6'h00;
      default: return bars[((p - (HS + HB)) * 8 / HV) % 8];
    endcase
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 5; b >= 0; b--) begin
      logic fb;
      fb = r[15] ^ d[b];
      r  = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // One frame starting at the vsync leading edge; one line may carry a bad period or hsync width.
  task automatic run_frame(input int fi, input int pat, input int vl, input int vsw,
                           input int bad_line, input int bad_hper, input int bad_hw, input int clr_line);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int l = 0; l < vl; l++) begin
      int per, hw;
      per = (l == bad_line) ? bad_hper : HT;
      hw  = (l == bad_line) ? bad_hw : HS;
      for (int p = 0; p < per; p++) begin
        @(negedge clk);
        hsync  = (p < hw) ? 1'b0 : 1'b1;
        vsync  = (l < vsw) ? 1'b0 : 1'b1;
        rrggbb = pix(pat, p, l);
        clear  = (l == clr_line) && (p == 0);
        if (l == 0 && p == 0) fstart = cyc;
        if (l == bad_line + 1 && p == 0) bad_cyc = cyc;
        if (vis(p, l)) c = crc_step(c, rrggbb);
      end
    end
    crc_m[fi] = c;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_locked"}, 32'(locked), 0);
    chk({nm, "_fc"}, 32'(frame_count), 0);
    chk({nm, "_err"}, 32'({err_hperiod, err_hwidth, err_vlines, err_vwidth}), 0);
    chk({nm, "_crc"}, 32'({frame_crc, crc_valid}), 0);
  endtask

  typedef struct {
    int pat, vl, vsw, bad_line, bad_hper, bad_hw, clr_line;
    logic lk; int fc; logic [3:0] err; logic pulse; int tchk;
  } vec_t;

  function automatic vec_t mk(input int pat, input int vl, input int vsw, input int bl, input int bper,
                              input int bhw, input int cl, input logic lk, input int fc,
                              input logic [3:0] err, input logic pulse, input int tchk);
    vec_t v;
    v.pat = pat; v.vl = vl; v.vsw = vsw; v.bad_line = bl; v.bad_hper = bper; v.bad_hw = bhw;
    v.clr_line = cl; v.lk = lk; v.fc = fc; v.err = err; v.pulse = pulse; v.tchk = tchk;
    return v;
  endfunction

  vec_t tbl [20];
  logic crc_on;

  initial begin
`ifdef VGA_CHK_CRC_EN
    crc_on = 1'b1;
`else
    crc_on = 1'b0;
`endif
    // err = {hperiod, hwidth, vlines, vwidth}; tchk 1 = lock-rise latency, 2 = hperiod/unlock latency
    tbl[0]  = mk(0, VT, 2, -1, HT, HS, -1, 0, 0,  4'b0000, 0, 0);
    tbl[1]  = mk(0, VT, 2, -1, HT, HS, -1, 1, 1,  4'b0000, 1, 1);
    tbl[2]  = mk(1, VT, 2, -1, HT, HS, -1, 1, 2,  4'b0000, 1, 0);
    tbl[3]  = mk(2, VT, 2, -1, HT, HS, -1, 1, 3,  4'b0000, 1, 0);
    tbl[4]  = mk(0, VT, 2, -1, HT, HS, -1, 1, 4,  4'b0000, 1, 0);
    tbl[5]  = mk(2, VT, 2, 5, HT-1, HS, -1, 0, 5, 4'b1000, 1, 2);
    tbl[6]  = mk(0, VT, 2, -1, HT, HS, -1, 0, 5,  4'b1000, 0, 0);
    tbl[7]  = mk(2, VT, 2, -1, HT, HS, -1, 1, 6,  4'b1000, 1, 1);
    tbl[8]  = mk(1, VT, 3, -1, HT, HS, -1, 0, 7,  4'b1001, 1, 0);
    tbl[9]  = mk(0, VT, 2, -1, HT, HS, -1, 0, 7,  4'b1001, 0, 0);
    tbl[10] = mk(2, VT-1, 2, -1, HT, HS, -1, 1, 8, 4'b1001, 1, 0);
    tbl[11] = mk(0, VT, 2, -1, HT, HS, -1, 0, 8,  4'b1011, 0, 0);
    tbl[12] = mk(1, VT, 2, -1, HT, HS, -1, 0, 8,  4'b1011, 0, 0);
    tbl[13] = mk(0, VT, 2, 4, HT, HS-1, -1, 0, 9, 4'b1111, 1, 0);
    tbl[14] = mk(0, VT, 2, -1, HT, HS, -1, 0, 9,  4'b1111, 0, 0);
    tbl[15] = mk(2, VT, 2, -1, HT, HS, -1, 1, 10, 4'b1111, 1, 0);
    tbl[16] = mk(0, VT, 2, 5, HT-1, HS, 6, 0, 0,  4'b1000, 1, 0);
    tbl[17] = mk(1, VT, 2, -1, HT, HS, -1, 0, 0,  4'b1000, 0, 0);
    tbl[18] = mk(2, VT, 2, -1, HT, HS, -1, 1, 1,  4'b1000, 1, 0);
    tbl[19] = mk(0, VT, 2, -1, HT, HS, 0, 1, 0,   4'b0000, 1, 0);

    rst_n = 1'b1; hsync = 1'b1; vsync = 1'b1; rrggbb = '0; clear = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      int p0;
      p0 = pulses;
      run_frame(i, tbl[i].pat, tbl[i].vl, tbl[i].vsw, tbl[i].bad_line, tbl[i].bad_hper,
                tbl[i].bad_hw, tbl[i].clr_line);
      chk($sformatf("f%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("f%0d_fc", i), 32'(frame_count), 32'(tbl[i].fc));
      chk($sformatf("f%0d_err", i), 32'({err_hperiod, err_hwidth, err_vlines, err_vwidth}), 32'(tbl[i].err));
      chk($sformatf("f%0d_pulses", i), 32'(pulses - p0), crc_on ? 32'(tbl[i].pulse) : 32'd0);
      if (crc_on && tbl[i].pulse) chk($sformatf("f%0d_crc", i), 32'(last_crc), 32'(crc_m[i-1]));
      if (!crc_on) chk($sformatf("f%0d_crc_tied", i), 32'(frame_crc), 0);
      if (tbl[i].tchk == 1) chk($sformatf("f%0d_lock_lat", i), 32'(lock_rise), 32'(fstart + 2));
      if (tbl[i].tchk == 2) begin
        chk($sformatf("f%0d_hper_lat", i), 32'(hper_rise), 32'(bad_cyc + 2));
        chk($sformatf("f%0d_unlock_lat", i), 32'(lock_fall), 32'(bad_cyc + 2));
      end
    end

    // frame_count is 4 bits wide here: 17 more locked frames run 1..15, 0, 1.
    for (int k = 1; k <= 17; k++) begin
      run_frame(19 + k, k % 3, VT, 2, -1, HT, HS, -1);
      chk($sformatf("wrap%0d_fc", k), 32'(frame_count), 32'(k % 16));
      chk($sformatf("wrap%0d_locked", k), 32'(locked), 1);
    end

    // Asynchronous reset in the middle of a frame, released in the visible area.
    run_frame(40, 0, 6, 2, -1, HT, HS, -1);
    chk("pre_rst_locked", 32'(locked), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(41, 0, VT, 2, -1, HT, HS, -1);
    chk("relock_1st_v", 32'(locked), 0);
    run_frame(42, 2, VT, 2, -1, HT, HS, -1);
    chk("relock_lat", 32'(lock_rise), 32'(fstart + 2));
    chk("relock_fc", 32'(frame_count), 1);
    chk("relock_err", 32'({err_hperiod, err_hwidth, err_vlines, err_vwidth}), 0);
    if (crc_on) chk("relock_crc", 32'(last_crc), 32'(crc_m[41]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
